// File: rtl/cnn_pkg.sv
// Shared definitions for the layer-4 pooled-output receive path.
//   CH        : channels per pooled word
//   POSITIONS : pooled words buffered per frame
//   W         : bits per element
//   state_t   : flatten-buffer sequencing states
//   word_t    : one pooled word, channel c in element [c]
package cnn_pkg;

  localparam int CH        = 16;
  localparam int POSITIONS = 4;
  localparam int W         = 8;

  localparam int NUM_ELEM  = POSITIONS * CH;
  localparam int WR_CNT_W  = (POSITIONS > 1) ? $clog2(POSITIONS) : 1;
  localparam int RD_IDX_W  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    STREAM  = 2'd1,
    FINISH  = 2'd2
  } state_t;

  typedef logic [CH-1:0][W-1:0] word_t;

endpackage

// File: rtl/flatten_mux.sv
// Combinational element select from the flattened feature-map buffer.
//   buf_flat : POSITIONS words packed position-major, word p at bits [p*CH*W +: CH*W]
//   rd_idx   : flattened element index (position*CH + channel)
//   elem     : selected element
module flatten_mux
  import cnn_pkg::*;
(
  input  logic [POSITIONS*CH*W-1:0] buf_flat,
  input  logic [RD_IDX_W-1:0]       rd_idx,
  output logic [W-1:0]              elem
);

  // Position-major order with channel 0 in the LSBs makes the flattened
  // index map directly onto consecutive W-bit slices of the buffer.
  always_comb begin
    elem = buf_flat[rd_idx*W +: W];
  end

endmodule

// File: rtl/pool_flatten_buffer.sv
// Buffers POSITIONS pooled words from layer 4 and streams them to the dense
// layer as a flattened, position-major byte stream.
//   clk, rst   : clock, synchronous active-high reset
//   maxflagin  : one-cycle pulse per pooled word, din captured with it
//   din        : pooled word, channel c in bits [c*W +: W]
//   clear      : synchronous abort (as rst, but overflow is kept)
//   dout/dvalid/dready/dlast : flattened element stream
//   done       : one-cycle pulse after the final handshake
//   overflow   : sticky, a word arrived while not collecting
//
// state   | meaning
// COLLECT | capturing pooled words into the buffer
// STREAM  | presenting buffered elements to the dense layer
// FINISH  | frame delivered, done pulse for one cycle
module pool_flatten_buffer
  import cnn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            maxflagin,
  input  logic [CH*W-1:0] din,
  input  logic            clear,
  output logic [W-1:0]    dout,
  output logic            dvalid,
  input  logic            dready,
  output logic            dlast,
  output logic            done,
  output logic            overflow
);

  localparam logic [RD_IDX_W-1:0] LAST_IDX = RD_IDX_W'(NUM_ELEM - 1);
  localparam logic [WR_CNT_W-1:0] LAST_WR  = WR_CNT_W'(POSITIONS - 1);

  state_t                  state_q, state_d;
  logic [WR_CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [RD_IDX_W-1:0]     rd_idx_q, rd_idx_d;
  word_t [POSITIONS-1:0]   mem_q, mem_d;
  logic [W-1:0]            dout_q, dout_d;
  logic                    dvalid_q, dvalid_d;
  logic                    dlast_q, dlast_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic [W-1:0]            elem_next;

  logic capture;
  logic handshake;

  assign capture   = maxflagin && (state_q == COLLECT);
  assign handshake = dvalid_q && dready;

  // State register
  always_ff @(posedge clk) begin
    if (rst || clear) state_q <= COLLECT;
    else              state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (capture && (wr_cnt_q == LAST_WR)) state_d = STREAM;
      STREAM:  if (handshake && (rd_idx_q == LAST_IDX)) state_d = FINISH;
      FINISH:  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Counters, buffer and sticky error
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_idx_d   = rd_idx_q;
    mem_d      = mem_q;
    overflow_d = overflow_q | (maxflagin && (state_q != COLLECT));
    if (capture) begin
      mem_d[wr_cnt_q] = din;
      wr_cnt_d        = (wr_cnt_q == LAST_WR) ? '0 : wr_cnt_q + 1'b1;
    end
    if ((state_q == STREAM) && handshake) begin
      rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
    end
  end

  // Select from the next buffer contents so element 0 is ready on the
  // same cycle dvalid rises, even if it was captured on the final edge.
  flatten_mux u_flatten_mux (
    .buf_flat (mem_d),
    .rd_idx   (rd_idx_d),
    .elem     (elem_next)
  );

  // Registered outputs, all derived from the next state
  always_comb begin
    dvalid_d = (state_d == STREAM);
    dlast_d  = (state_d == STREAM) && (rd_idx_d == LAST_IDX);
    done_d   = (state_d == FINISH);
    dout_d   = (state_d == STREAM) ? elem_next : dout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      rd_idx_q   <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_cnt_q   <= '0;
      rd_idx_q   <= '0;
      dout_q     <= '0;
      dvalid_q   <= 1'b0;
      dlast_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_idx_q   <= rd_idx_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      dlast_q    <= dlast_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer contents carry no reset value
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout     = dout_q;
  assign dvalid   = dvalid_q;
  assign dlast    = dlast_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: doc/pool_flatten_buffer.md
Name: pool_flatten_buffer

Overview:
- Receiving end of the 4th conv/ReLU/maxpool stage's pooled-output interface.
- Captures each 16-channel pooled word presented with the pool-valid flag and buffers POSITIONS words.
- Then streams the buffered feature map as a flattened byte stream, position-major, to the dense-layer input under a valid/ready handshake.
- Sits between the layer-4 control procedure and the fully-connected layer controller.

Parameters:
- CH, 16, channels per pooled word
- POSITIONS, 4, pooled words per frame (pulses per frame from layer 4)
- W, 8, bits per element

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- maxflagin  in  1  pooled word valid; one-cycle pulse per word from layer 4
- din  in  CH*W  pooled word; channel c in bits [c*W +: W], channel 0 = LSBs
- clear  in  1  synchronous abort: discard buffer, return to COLLECT
- dout  out  W  flattened element
- dvalid  out  1  dout valid
- dready  in  1  downstream accepts dout when dvalid & dready
- dlast  out  1  high with the final element (index POSITIONS*CH-1)
- done  out  1  one-cycle pulse after the final handshake
- overflow  out  1  sticky error: maxflagin arrived while not in COLLECT

Behaviour:
- Reset values (rst=1 at a clock edge): state=COLLECT, wr_cnt=0, rd_idx=0, dout=0, dvalid=0, dlast=0, done=0, overflow=0. Buffer contents are don't-care.
- clear has the same effect as rst, except that overflow is preserved. rst has priority over clear.
- State COLLECT:
  - On maxflagin=1, store din into mem[wr_cnt] and increment wr_cnt.
  - When the capture is at wr_cnt=POSITIONS-1, the next state is STREAM and wr_cnt wraps to 0.
  - maxflagin high on consecutive cycles captures every cycle. No gaps are required.
- State STREAM:
  - dvalid=1. dout = mem[rd_idx / CH] channel (rd_idx % CH), so the order is pos0 ch0..ch15, pos1 ch0..ch15, and so on.
  - Latency: dvalid rises the cycle after the final capture edge. Element 0 is on dout in that same cycle.
  - dout, dlast and dvalid hold stable while dready=0.
  - On a handshake, rd_idx increments. dout updates in the next cycle: registered output, at most one element per cycle.
  - dlast=1 exactly when rd_idx = POSITIONS*CH-1.
  - A handshake with dlast=1 moves to FINISH: dvalid=0, dlast=0, rd_idx=0.
- State FINISH: done=1 for exactly one cycle, then COLLECT.
- A maxflagin in STREAM or FINISH is dropped, sets overflow, and leaves buffer and output unchanged.
- dready with dvalid=0 has no effect.
- clear or rst mid-STREAM: dvalid drops the next cycle, no done pulse, partial frame lost.
- Data is passed unsigned/raw. No arithmetic on element values. Post-ReLU values are non-negative.
- Counter widths are clog2 of their ranges. rd_idx range is 0..POSITIONS*CH-1 (63 by default).
- States are encoded as an enum of 2 bits.

Decomposition:
- Shared package (cnn_pkg):
  - CH, POSITIONS and W constants
  - state enum typedef {COLLECT, STREAM, FINISH}
  - packed word typedef logic [CH-1:0][W-1:0]
- One sub-module: flatten_mux, a combinational select of element rd_idx from a POSITIONS x CH buffer. The registered dout stays in the top module.

Test Plan:
- Basic frame:
  - Stimulus: after reset, 4 maxflagin pulses 3 cycles apart; word p has channel c = p*16+c; dready=1 throughout.
  - Response: dvalid rises the cycle after the 4th capture. dout = 0,1,...,63 on consecutive cycles. dlast only with 63. done pulses once, the cycle after the last handshake.
- Back-pressure:
  - Stimulus: same frame; dready toggles 1,0,0,1,... .
  - Response: dout holds its value during dready=0, no element is skipped or repeated, the 64 accepted values are 0..63.
- Back-to-back pulses:
  - Stimulus: maxflagin high 4 consecutive cycles with words A, B, C, D (all channels = 8'hA0, 8'hB0, 8'hC0, 8'hD0).
  - Response: stream is 16x A0, 16x B0, 16x C0, 16x D0.
- Overflow:
  - Stimulus: maxflagin pulse during STREAM with word 8'hFF.
  - Response: overflow=1 and stays 1, no FF appears in the stream, the current frame completes normally.
- Mid-stream abort:
  - Stimulus: clear at element 20, then a new frame of all 8'h11.
  - Response: dvalid=0 the next cycle, no done pulse. The new stream is 64x 8'h11 with done. overflow is unchanged by clear.
- Reset mid-collect:
  - Stimulus: 2 captures, rst, then 4 captures of values 0..63.
  - Response: the stream is 0..63. The earlier partial words never appear.
